// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request bridge from a byte-addressed
// request/response port to a word-wide synchronous RAM port with byte enables.
// Sub-word stores replicate data across lanes; loads are lane-extracted and
// sign/zero extended before being returned.
module load_store_unit #(
  parameter int WORD_ADDR_W = 30
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [WORD_ADDR_W-1:0] mem_address,
  output logic                   mem_wren,
  output logic [3:0]             mem_byteena,
  output logic [31:0]            mem_data,
  input  logic [31:0]            mem_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Request is illegal when the size code is reserved or the address is not
  // naturally aligned to the access size.
  function automatic logic f_is_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = lo[0];
      2'b10:   err = |lo;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Lanes touched by an aligned access.
  function automatic logic [3:0] f_byteena(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00: begin
        case (lo)
          2'b00:   be = 4'b0001;
          2'b01:   be = 4'b0010;
          2'b10:   be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-justified store data is replicated so every enabled lane sees it.
  function automatic logic [31:0] f_replicate(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the RAM word and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  lane,
                                            input logic [31:0] q);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = q[7:0];
      2'b01:   b = q[15:8];
      2'b10:   b = q[23:16];
      default: b = q[31:24];
    endcase
    h = lane[1] ? q[31:16] : q[15:0];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      2'b10:   r = q;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic                   r_we;
  logic [1:0]             r_size;
  logic                   r_uns;
  logic [1:0]             r_lane;
  logic [3:0]             r_be;
  logic [WORD_ADDR_W-1:0] r_mem_address;
  logic [31:0]            r_mem_data;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic                   w_accept;
  logic                   w_req_err;

  assign w_accept  = (r_state == S_IDLE) & req_valid;
  assign w_req_err = f_is_err(req_size, req_addr[1:0]);

  // Next-state selection for the request sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next_state = w_req_err ? S_RESP : S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: w_next_state = r_we ? S_RESP : S_WAIT;
      S_WAIT:  w_next_state = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture request attributes on acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_size <= 2'b00;
      r_uns  <= 1'b0;
      r_lane <= 2'b00;
      r_be   <= 4'b0000;
    end else if (w_accept) begin
      r_we   <= req_we;
      r_size <= req_size;
      r_uns  <= req_unsigned;
      r_lane <= req_addr[1:0];
      r_be   <= f_byteena(req_size, req_addr[1:0]);
    end
  end

  // RAM address/data only move for legal requests, so errors leave the port untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_address <= '0;
      r_mem_data    <= 32'h0000_0000;
    end else if (w_accept && !w_req_err) begin
      r_mem_address <= req_addr[WORD_ADDR_W+1:2];
      r_mem_data    <= f_replicate(req_size, req_wdata);
    end
  end

  // Response payload: cleared on accept, filled from RAM in WAIT, held through RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= w_req_err;
    end else if (r_state == S_WAIT) begin
      r_rdata <= f_extract(r_size, r_uns, r_lane, mem_q);
    end else if ((r_state == S_RESP) && resp_ready) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end
  end

  // Handshake and RAM strobes come only from the state register.
  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign mem_wren    = (r_state == S_ISSUE) & r_we;
  assign mem_byteena = (r_state == S_ISSUE) ? r_be : 4'b0000;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-array reference model predicts
// every response, lane enable and RAM address; a negedge compare process
// checks the DUT against those predictions on every cycle.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] mem_address;
  logic        mem_wren;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic [31:0] mem_q;

  load_store_unit #(.WORD_ADDR_W(30)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_wren     (mem_wren),
    .mem_byteena  (mem_byteena),
    .mem_data     (mem_data),
    .mem_q        (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM seen by the DUT: byte-lane writes, registered read.
  logic [31:0] ram [0:63];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0000_0000;
    ram[16] = 32'h8899_AABB;
    mem_q   = 32'h0000_0000;
  end
  always @(posedge clock) begin
    if (mem_wren) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_byteena[l]) ram[mem_address[5:0]][8*l +: 8] <= mem_data[8*l +: 8];
      end
    end
    mem_q <= ram[mem_address[5:0]];
  end

  // Reference model: memory as individual bytes.
  logic [7:0] mm [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    mm[8'h40] = 8'hBB; mm[8'h41] = 8'hAA; mm[8'h42] = 8'h99; mm[8'h43] = 8'h88;
  end

  function automatic bit m_err(input int size, input int a);
    return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns, input int a);
    int n;
    logic [31:0] v;
    logic [31:0] one;
    n = 1 << size; v = 32'd0; one = 32'd1;
    for (int i = 0; i < n; i++) v = v | ({24'd0, mm[a + i]} << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((one << (8 * n)) - one);
    return v;
  endfunction

  function automatic logic [3:0] m_be(input int size, input int a);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < (1 << size); i++) be[(a % 4) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_mdata(input int size, input logic [31:0] w);
    logic [31:0] d;
    int n;
    n = 1 << size;
    for (int j = 0; j < 4; j++) d[8 * j +: 8] = w[8 * (j % n) +: 8];
    return d;
  endfunction

  // Expected outputs for the cycle about to be sampled.
  logic        e_req_ready, e_resp_valid, e_wren, e_err, e_chk_rsp, e_chk_mdata;
  logic [3:0]  e_be;
  logic [29:0] e_addr;
  logic [31:0] e_rdata, e_mdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    chk("req_ready",   {31'd0, req_ready},   {31'd0, e_req_ready});
    chk("resp_valid",  {31'd0, resp_valid},  {31'd0, e_resp_valid});
    chk("mem_wren",    {31'd0, mem_wren},    {31'd0, e_wren});
    chk("mem_byteena", {28'd0, mem_byteena}, {28'd0, e_be});
    chk("mem_address", {2'd0, mem_address},  {2'd0, e_addr});
    if (e_chk_rsp) begin
      chk("resp_rdata", resp_rdata, e_rdata);
      chk("resp_err",   {31'd0, resp_err}, {31'd0, e_err});
    end
    if (e_chk_mdata) chk("mem_data", mem_data, e_mdata);
  end

  task automatic set_idle();
    e_req_ready = 1'b1; e_resp_valid = 1'b0; e_wren = 1'b0; e_be = 4'b0000;
    e_chk_rsp = 1'b0; e_chk_mdata = 1'b0;
  endtask

  task automatic set_reset_exp();
    set_idle();
    e_addr = 30'd0; e_chk_rsp = 1'b1; e_rdata = 32'd0; e_err = 1'b0;
    e_chk_mdata = 1'b1; e_mdata = 32'd0;
  endtask

  // Mid-cycle asynchronous reset, checked immediately, then released.
  task automatic do_reset();
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    set_reset_exp();
    #1;
    chk("rst_now_wren",  {31'd0, mem_wren},    32'd0);
    chk("rst_now_be",    {28'd0, mem_byteena}, 32'd0);
    chk("rst_now_rvld",  {31'd0, resp_valid},  32'd0);
    chk("rst_now_ready", {31'd0, req_ready},   32'd1);
    chk("rst_now_addr",  {2'd0, mem_address},  32'd0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    e_chk_rsp = 1'b0; e_chk_mdata = 1'b0;
    @(posedge clock); #1;
  endtask

  // One request/response. abort = k resets the DUT in busy cycle k.
  task automatic txn(input bit we, input int size, input bit uns, input int addr,
                     input logic [31:0] wdata, input int hold,
                     input logic [31:0] lit, input bit lit_en, input int abort);
    bit          err;
    int          lat;
    logic [31:0] exp_r;
    err   = m_err(size, addr);
    lat   = err ? 1 : (we ? 2 : 3);
    exp_r = (err || we) ? 32'd0 : m_load(size, uns, addr);
    if (lit_en) chk("model_pin", exp_r, lit);
    req_we = we; req_size = size[1:0]; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10;
    req_addr = 32'hFFFF_FFF0; req_wdata = 32'hDEAD_0000;
    if (!err) e_addr = addr[31:2];
    e_req_ready = 1'b0;
    for (int k = 1; k < lat; k++) begin
      e_resp_valid = 1'b0;
      e_be         = (k == 1) ? m_be(size, addr) : 4'b0000;
      e_wren       = (k == 1) && we;
      e_chk_mdata  = e_wren;
      e_mdata      = m_mdata(size, wdata);
      if (abort == k) begin
        #2;
        do_reset();
        return;
      end
      @(posedge clock); #1;
    end
    if (we && !err) begin
      for (int i = 0; i < (1 << size); i++) mm[addr + i] = wdata[8 * i +: 8];
    end
    e_be = 4'b0000; e_wren = 1'b0; e_chk_mdata = 1'b0;
    e_resp_valid = 1'b1; e_chk_rsp = 1'b1; e_rdata = exp_r; e_err = err;
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    set_idle();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    set_reset_exp();
    #12 reset_n = 1'b1;
    e_chk_rsp = 1'b0; e_chk_mdata = 1'b0;
    @(posedge clock); #1;

    txn(1'b0, 2, 1'b0, 32'h40, 32'h0,         0, 32'h0,         1'b0, 2);
    txn(1'b1, 2, 1'b0, 32'h40, 32'h1122_3344, 0, 32'h0,         1'b0, 1);
    txn(1'b0, 2, 1'b0, 32'h40, 32'h0,         0, 32'h8899_AABB, 1'b1, 0);
    txn(1'b0, 0, 1'b0, 32'h41, 32'h0,         0, 32'hFFFF_FFAA, 1'b1, 0);
    txn(1'b0, 1, 1'b1, 32'h42, 32'h0,         0, 32'h0000_8899, 1'b1, 0);
    txn(1'b0, 1, 1'b0, 32'h42, 32'h0,         0, 32'hFFFF_8899, 1'b1, 0);
    txn(1'b1, 0, 1'b0, 32'h43, 32'h0000_00CC, 0, 32'h0,         1'b1, 0);
    txn(1'b0, 2, 1'b0, 32'h40, 32'h0,         0, 32'hCC99_AABB, 1'b1, 0);
    txn(1'b0, 2, 1'b0, 32'h42, 32'h0,         0, 32'h0,         1'b1, 0);
    txn(1'b1, 3, 1'b0, 32'h40, 32'h5555_5555, 0, 32'h0,         1'b1, 0);
    txn(1'b0, 2, 1'b0, 32'h40, 32'h0,         5, 32'hCC99_AABB, 1'b1, 0);
    txn(1'b0, 0, 1'b1, 32'h40, 32'h0,         0, 32'h0000_00BB, 1'b1, 0);
    txn(1'b0, 0, 1'b0, 32'h42, 32'h0,         0, 32'hFFFF_FF99, 1'b1, 0);
    txn(1'b0, 1, 1'b0, 32'h41, 32'h0,         0, 32'h0,         1'b1, 0);
    txn(1'b1, 1, 1'b0, 32'h46, 32'hABCD_1234, 0, 32'h0,         1'b1, 0);
    txn(1'b1, 0, 1'b0, 32'h45, 32'h7777_77A5, 2, 32'h0,         1'b1, 0);
    txn(1'b0, 2, 1'b0, 32'h44, 32'h0,         0, 32'h1234_A500, 1'b1, 0);
    txn(1'b0, 1, 1'b0, 32'h46, 32'h0,         0, 32'h0000_1234, 1'b1, 0);
    txn(1'b1, 2, 1'b0, 32'h48, 32'hDEAD_BEEF, 0, 32'h0,         1'b1, 0);
    txn(1'b0, 1, 1'b0, 32'h4A, 32'h0,         0, 32'hFFFF_DEAD, 1'b1, 0);
    txn(1'b0, 0, 1'b1, 32'h49, 32'h0,         0, 32'h0000_00BE, 1'b1, 0);
    txn(1'b0, 3, 1'b1, 32'h48, 32'h0,         0, 32'h0,         1'b1, 0);
    txn(1'b1, 2, 1'b0, 32'h4E, 32'h0000_0001, 0, 32'h0,         1'b1, 0);
    txn(1'b0, 2, 1'b0, 32'h4C, 32'h0,         0, 32'h0000_0000, 1'b1, 0);

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
